// File: rtl/datapath_pkg.sv
// Shared width and ALU operation encoding for the single-bus datapath.
package datapath_pkg;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        ALU_NONE = 2'd0,
        ALU_INC  = 2'd1,
        ALU_AND  = 2'd2,
        ALU_OR   = 2'd3
    } alu_op_e;

    // IncPC wins over AND, which wins over OR.
    function automatic alu_op_e alu_decode(input logic inc_sel, input logic and_sel,
                                           input logic or_sel);
        if (inc_sel)
            return ALU_INC;
        else if (and_sel)
            return ALU_AND;
        else if (or_sel)
            return ALU_OR;
        return ALU_NONE;
    endfunction

endpackage

// File: rtl/datapath_register32.sv
// 32-bit load-enable register with asynchronous active-high clear.
module register32
    import datapath_pkg::*;
(
    input  logic                  clear,
    input  logic                  Clock,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] D,
    output logic [DATA_WIDTH-1:0] Q
);

    logic [DATA_WIDTH-1:0] q_d;
    logic [DATA_WIDTH-1:0] q_q;

    always_comb begin
        q_d = q_q;
        if (enable)
            q_d = D;
    end

    always_ff @(posedge Clock or posedge clear) begin
        if (clear)
            q_q <= '0;
        else
            q_q <= q_d;
    end

    assign Q = q_q;

endmodule

// File: rtl/datapath.sv
// Single-bus CPU datapath: register file slice, prioritised bus mux, MDR mux and ALU.
module datapath
    import datapath_pkg::*;
(
    input  logic                  Clock,
    input  logic                  clear,
    input  logic                  PCout,
    input  logic                  Zlowout,
    input  logic                  MDRout,
    input  logic                  R2out,
    input  logic                  R3out,
    input  logic                  MARin,
    input  logic                  Zin,
    input  logic                  PCin,
    input  logic                  MDRin,
    input  logic                  IRin,
    input  logic                  Yin,
    input  logic                  R1in,
    input  logic                  R2in,
    input  logic                  R3in,
    input  logic                  IncPC,
    input  logic                  AND,
    input  logic                  OR,
    input  logic                  Read,
    input  logic [DATA_WIDTH-1:0] Mdatain,
    output logic [DATA_WIDTH-1:0] BusMuxOut,
    output logic [DATA_WIDTH-1:0] R1q,
    output logic [DATA_WIDTH-1:0] PCq,
    output logic [DATA_WIDTH-1:0] IRq,
    output logic [DATA_WIDTH-1:0] MARq,
    output logic [DATA_WIDTH-1:0] ZLowq
);

    logic [DATA_WIDTH-1:0]   r2_q, r3_q, mdr_q, y_q, zhigh_q;
    logic [DATA_WIDTH-1:0]   bus;
    logic [DATA_WIDTH-1:0]   mdr_d;
    logic [2*DATA_WIDTH-1:0] alu_res;
    alu_op_e                 alu_op;

    always_comb begin
        bus = '0;
        if (PCout)
            bus = PCq;
        else if (Zlowout)
            bus = ZLowq;
        else if (MDRout)
            bus = mdr_q;
        else if (R2out)
            bus = r2_q;
        else if (R3out)
            bus = r3_q;
    end

    assign BusMuxOut = bus;
    assign mdr_d     = Read ? Mdatain : bus;
    assign alu_op    = alu_decode(IncPC, AND, OR);

    // A operand is Y, B operand is the bus; upper half stays zero for every op.
    always_comb begin
        alu_res = '0;
        case (alu_op)
            ALU_INC: alu_res = {{DATA_WIDTH{1'b0}}, bus + {{(DATA_WIDTH-1){1'b0}}, 1'b1}};
            ALU_AND: alu_res = {{DATA_WIDTH{1'b0}}, y_q & bus};
            ALU_OR:  alu_res = {{DATA_WIDTH{1'b0}}, y_q | bus};
            default: alu_res = '0;
        endcase
    end

    register32 u_r1    (.clear(clear), .Clock(Clock), .enable(R1in),  .D(bus),   .Q(R1q));
    register32 u_r2    (.clear(clear), .Clock(Clock), .enable(R2in),  .D(bus),   .Q(r2_q));
    register32 u_r3    (.clear(clear), .Clock(Clock), .enable(R3in),  .D(bus),   .Q(r3_q));
    register32 u_pc    (.clear(clear), .Clock(Clock), .enable(PCin),  .D(bus),   .Q(PCq));
    register32 u_ir    (.clear(clear), .Clock(Clock), .enable(IRin),  .D(bus),   .Q(IRq));
    register32 u_mar   (.clear(clear), .Clock(Clock), .enable(MARin), .D(bus),   .Q(MARq));
    register32 u_mdr   (.clear(clear), .Clock(Clock), .enable(MDRin), .D(mdr_d), .Q(mdr_q));
    register32 u_y     (.clear(clear), .Clock(Clock), .enable(Yin),   .D(bus),   .Q(y_q));
    register32 u_zlow  (.clear(clear), .Clock(Clock), .enable(Zin),
                        .D(alu_res[DATA_WIDTH-1:0]), .Q(ZLowq));
    register32 u_zhigh (.clear(clear), .Clock(Clock), .enable(Zin),
                        .D(alu_res[2*DATA_WIDTH-1:DATA_WIDTH]), .Q(zhigh_q));

    // ZHigh has no observation port; it is kept for the multiply/divide extension.
    logic unused_zhigh;
    assign unused_zhigh = ^zhigh_q;

endmodule

// File: tb/tb_datapath.sv
// Directed-vector bench for the single-bus datapath.
module tb_datapath;

    logic        Clock = 1'b0;
    logic        clear;
    logic        PCout, Zlowout, MDRout, R2out, R3out;
    logic        MARin, Zin, PCin, MDRin, IRin, Yin, R1in, R2in, R3in;
    logic        IncPC, AND, OR, Read;
    logic [31:0] Mdatain;
    logic [31:0] BusMuxOut, R1q, PCq, IRq, MARq, ZLowq;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    datapath dut (
        .Clock(Clock), .clear(clear),
        .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .R2out(R2out), .R3out(R3out),
        .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .R1in(R1in), .R2in(R2in), .R3in(R3in),
        .IncPC(IncPC), .AND(AND), .OR(OR), .Read(Read), .Mdatain(Mdatain),
        .BusMuxOut(BusMuxOut), .R1q(R1q), .PCq(PCq), .IRq(IRq), .MARq(MARq), .ZLowq(ZLowq)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        {PCout, Zlowout, MDRout, R2out, R3out} = '0;
        {MARin, Zin, PCin, MDRin, IRin, Yin, R1in, R2in, R3in} = '0;
        {IncPC, AND, OR, Read} = '0;
        Mdatain = '0;
    endtask

    // Advance one rising edge, settle, then drop every control.
    task automatic cyc();
        @(posedge Clock);
        #1;
        idle();
    endtask

    initial begin
        idle();
        clear = 1'b1;
        #3;
        chk("rst_r1",  R1q,       32'h0);
        chk("rst_pc",  PCq,       32'h0);
        chk("rst_ir",  IRq,       32'h0);
        chk("rst_mar", MARq,      32'h0);
        chk("rst_z",   ZLowq,     32'h0);
        chk("rst_bus", BusMuxOut, 32'h0);
        @(negedge Clock);
        clear = 1'b0;
        @(posedge Clock);
        #1;

        // Load R2, R3, R1 through MDR
        Mdatain = 32'h12; Read = 1; MDRin = 1; cyc();
        MDRout = 1; R2in = 1; cyc();
        Mdatain = 32'h14; Read = 1; MDRin = 1; cyc();
        MDRout = 1; R3in = 1; cyc();
        Mdatain = 32'h18; Read = 1; MDRin = 1; cyc();
        MDRout = 1; R1in = 1; cyc();
        chk("load_r1", R1q, 32'h18);
        R2out = 1; #1 chk("load_r2", BusMuxOut, 32'h12); idle();
        R3out = 1; #1 chk("load_r3", BusMuxOut, 32'h14); idle();

        // Instruction fetch from PC=0
        PCout = 1; MARin = 1; IncPC = 1; Zin = 1;
        #1 chk("fetch_bus", BusMuxOut, 32'h0);
        cyc();
        chk("fetch_mar", MARq,  32'h0);
        chk("fetch_z",   ZLowq, 32'h1);
        Zlowout = 1; PCin = 1; Read = 1; MDRin = 1; Mdatain = 32'h28918000; cyc();
        chk("fetch_pc", PCq, 32'h1);
        MDRout = 1; IRin = 1;
        #1 chk("fetch_mdr", BusMuxOut, 32'h28918000);
        cyc();
        chk("fetch_ir", IRq, 32'h28918000);

        // AND
        R2out = 1; Yin = 1; cyc();
        R3out = 1; AND = 1; Zin = 1; cyc();
        chk("and_z", ZLowq, 32'h10);
        Zlowout = 1; R1in = 1; cyc();
        chk("and_r1", R1q, 32'h10);

        // OR
        R2out = 1; Yin = 1; cyc();
        R3out = 1; OR = 1; Zin = 1; cyc();
        chk("or_z", ZLowq, 32'h16);
        Zlowout = 1; R1in = 1; cyc();
        chk("or_r1", R1q, 32'h16);

        // Bus and ALU priority
        PCout = 1; MDRout = 1;   #1 chk("prio_pc_mdr", BusMuxOut, 32'h1);        idle();
        Zlowout = 1; MDRout = 1; #1 chk("prio_z_mdr",  BusMuxOut, 32'h16);       idle();
        MDRout = 1; R2out = 1;   #1 chk("prio_mdr_r2", BusMuxOut, 32'h28918000); idle();
        #1 chk("bus_none", BusMuxOut, 32'h0);
        R3out = 1; AND = 1; OR = 1; Zin = 1; cyc();
        chk("alu_and_over_or", ZLowq, 32'h10);
        R3out = 1; IncPC = 1; AND = 1; Zin = 1; cyc();
        chk("alu_inc_over_and", ZLowq, 32'h15);
        Zin = 1; cyc();
        chk("alu_none", ZLowq, 32'h0);

        // PC wrap and same-register source/destination
        Mdatain = 32'hFFFF_FFFF; Read = 1; MDRin = 1; cyc();
        MDRout = 1; PCin = 1; cyc();
        chk("wrap_pc", PCq, 32'hFFFF_FFFF);
        PCout = 1; PCin = 1; cyc();
        chk("self_pc", PCq, 32'hFFFF_FFFF);
        PCout = 1; IncPC = 1; Zin = 1; cyc();
        chk("wrap_z", ZLowq, 32'h0);

        // Restore PC=1, then clear between edges with a load pending
        Mdatain = 32'h1; Read = 1; MDRin = 1; cyc();
        MDRout = 1; PCin = 1; cyc();
        chk("pre_rst_pc", PCq, 32'h1);
        chk("pre_rst_r1", R1q, 32'h16);
        PCout = 1; R1in = 1; MARin = 1;
        #1 clear = 1'b1;
        #1;
        chk("clr_r1",  R1q,       32'h0);
        chk("clr_pc",  PCq,       32'h0);
        chk("clr_ir",  IRq,       32'h0);
        chk("clr_mar", MARq,      32'h0);
        chk("clr_z",   ZLowq,     32'h0);
        chk("clr_bus", BusMuxOut, 32'h0);
        idle();
        Mdatain = 32'h55; Read = 1; MDRin = 1;
        @(posedge Clock);
        #1;
        idle();
        @(negedge Clock);
        clear = 1'b0;
        MDRout = 1; #1 chk("clr_no_load", BusMuxOut, 32'h0); idle();
        @(posedge Clock);
        #1;
        Mdatain = 32'h55; Read = 1; MDRin = 1; cyc();
        MDRout = 1; #1 chk("post_clr_load", BusMuxOut, 32'h55); idle();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
